uart_bus_arbiter: RTL and testbench
===================================

# uart_bus_arbiter

Two-master arbiter that shares the single UART register port (2-bit address, 8-bit data, strobe/ack) between the external host bus and an on-chip requester. It serialises accesses, grants round-robin on contention, drives one slave transaction at a time, returns read data and ack to the winner, and aborts with an error pulse if the slave never acks. It sits between the top level's bus pins/internal logic and the UART's register interface, all in one clock domain. Crossing into another clock domain is out of scope.

## Interface
- TIMEOUT, 15: cycles in BUS without s_ack before abort. Legal range ≥1. Counter width is clog2(TIMEOUT+1).

- clk  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_stb / m1_stb  in  1  request from master 0 / 1
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  2  register address
- m0_wdata / m1_wdata  in  8  write data
- m0_rdata / m1_rdata  out  8  read data, valid while the matching ack is high
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  one-cycle timeout pulse
- s_stb  out  1  slave strobe
- s_we  out  1  slave write enable
- s_addr  out  2  slave address
- s_wdata  out  8  slave write data
- s_rdata  in  8  slave read data
- s_ack  in  1  slave acknowledge
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  high in any state other than IDLE

## Operation
- Master protocol:
  - Master holds stb, we, addr and wdata stable until it sees ack or err.
  - In the cycle after ack/err, the master either drops stb or presents a new request.
- FSM has three states: IDLE, BUS, RESP.
- IDLE:
  - No m_stb: stay in IDLE.
  - Exactly one m_stb: grant that master.
  - Both m_stb: grant the master that was not served last (`last` flag).
  - On grant: latch the winner's we/addr/wdata into the s_* registers, set grant, clear the timeout counter, go to BUS.
- BUS:
  - s_stb=1; s_we/s_addr/s_wdata come from the latched values.
  - Counter increments every cycle in which s_ack=0.
  - s_ack=1 sampled: capture s_rdata into the winner's rdata register (reads and writes alike), go to RESP with ok.
  - Counter reaches TIMEOUT with s_ack still 0: set the winner's rdata to 8'hFF, go to RESP with err.
  - s_ack and the timeout in the same cycle: s_ack wins.
- RESP:
  - s_stb=0.
  - Pulse the winner's ack (or err) for exactly one cycle.
  - Set last = winner, clear grant, go to IDLE.
- Behaviour at edges:
  - Master dropping stb during BUS does not cancel the transaction; it completes and the ack/err pulse is still issued.
  - s_ack outside BUS is ignored.
  - The loser's request is held off and is served in the next IDLE.
  - The non-granted master's ack, err and rdata do not change.
- Reset (asynchronous, immediate, including mid-transaction):
  - State = IDLE, last = 1 (master 0 wins the first tie).
  - s_stb, s_we, s_addr, s_wdata = 0.
  - All acks and errs = 0; both rdata = 8'h00.
  - grant = 00, busy = 0, counter = 0.
  - An interrupted transaction gets no ack or err.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Request visible at edge E0: s_stb high in the cycle after E0.
- Slave acks in its first s_stb cycle: m_ack is high two cycles after the request is sampled.
- Throughput: one transaction per 3 cycles minimum (IDLE→BUS→RESP).
- A back-to-back request from the same master is sampled in IDLE at the edge after the ack cycle.
- Timeout: s_stb stays high for exactly TIMEOUT cycles, then the err pulse follows in the next cycle.
- Under continuous contention, grants strictly alternate 0,1,0,1…

## Test plan
- Reset: hold reset_n=0 → all outputs 0 and rdata=00. Assert reset_n=0 mid-BUS → s_stb falls without waiting for a clock edge; no ack.
- Single write: m0 write addr=0, wdata=8'h41, slave acks in its first cycle → s_stb high 1 cycle with s_addr=0, s_wdata=41, s_we=1; m0_ack a single pulse 2 cycles after the request; m1 outputs unchanged.
- Single read: m1 read addr=2, slave returns 8'h5A with ack after 3 cycles → s_stb high 3 cycles; m1_rdata=5A while m1_ack is high.
- Contention: both masters request continuously out of reset → order m0,m1,m0,m1; grant one-hot and never 11.
- Timeout: TIMEOUT=15, slave never acks → s_stb high 15 cycles, then m0_err pulses with m0_rdata=FF, no ack; the next request completes normally.
- Ack at limit: s_ack arrives in the same cycle the timeout is reached → ack pulse, no err; master drops stb mid-BUS → ack still issued.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// Two-master arbiter for the UART register port: round-robin grant, one slave
// transaction at a time, registered ack/err/rdata back to the winner.
module uart_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m0_stb,
    input  logic       m0_we,
    input  logic [1:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic [7:0] m0_rdata,
    output logic       m0_ack,
    output logic       m0_err,
    input  logic       m1_stb,
    input  logic       m1_we,
    input  logic [1:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic [7:0] m1_rdata,
    output logic       m1_ack,
    output logic       m1_err,
    output logic       s_stb,
    output logic       s_we,
    output logic [1:0] s_addr,
    output logic [7:0] s_wdata,
    input  logic [7:0] s_rdata,
    input  logic       s_ack,
    output logic [1:0] grant,
    output logic       busy
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;   // index of the master served most recently
    logic            win_q, win_d;     // index of the current owner
    logic            s_stb_q, s_stb_d;
    logic            s_we_q, s_we_d;
    logic [1:0]      s_addr_q, s_addr_d;
    logic [7:0]      s_wdata_q, s_wdata_d;
    logic [1:0]      grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            ack0_q, ack0_d, ack1_q, ack1_d;
    logic            err0_q, err0_d, err1_q, err1_d;
    logic [7:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic            sel;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        win_d     = win_q;
        s_stb_d   = s_stb_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        sel       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0_stb || m1_stb) begin
                    // On a tie the master not served last wins.
                    sel       = (m0_stb && m1_stb) ? ~last_q : m1_stb;
                    win_d     = sel;
                    s_stb_d   = 1'b1;
                    s_we_d    = sel ? m1_we : m0_we;
                    s_addr_d  = sel ? m1_addr : m0_addr;
                    s_wdata_d = sel ? m1_wdata : m0_wdata;
                    grant_d   = sel ? 2'b10 : 2'b01;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StBus;
                end
            end
            StBus: begin
                if (s_ack) begin
                    if (win_q) begin
                        rdata1_d = s_rdata;
                        ack1_d   = 1'b1;
                    end else begin
                        rdata0_d = s_rdata;
                        ack0_d   = 1'b1;
                    end
                    s_stb_d = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    if (win_q) begin
                        rdata1_d = 8'hFF;
                        err1_d   = 1'b1;
                    end else begin
                        rdata0_d = 8'hFF;
                        err0_d   = 1'b1;
                    end
                    s_stb_d = 1'b0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                last_d  = win_q;
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            win_q     <= 1'b0;
            s_stb_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= 2'b00;
            s_wdata_q <= 8'h00;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 8'h00;
            rdata1_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            win_q     <= win_d;
            s_stb_q   <= s_stb_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign s_stb    = s_stb_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign grant    = grant_q;
    assign busy     = busy_q;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_err   = err0_q;
    assign m1_err   = err1_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: vector table of single transactions plus
// hand sequences for reset, contention and mid-transaction reset.
module tb_uart_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       m0_stb, m0_we, m1_stb, m1_we;
    logic [1:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic [7:0] m0_rdata, m1_rdata;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic       s_stb, s_we, s_ack;
    logic [1:0] s_addr, grant;
    logic [7:0] s_wdata, s_rdata;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_bus_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         m;
        bit         we;
        logic [1:0] addr;
        logic [7:0] wdata;
        int         lat;      // s_stb cycle in which the slave acks; 0 = never
        logic [7:0] srd;
        bit         drop;     // master drops stb in the first BUS cycle
        bit         exp_ack;
        bit         exp_err;
        logic [7:0] exp_rdata;
        int         exp_nstb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit m, input bit stb, input bit we, input logic [1:0] addr,
                           input logic [7:0] wdata);
        if (m) begin
            m1_stb = stb; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_stb = stb; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         nstb;
        logic [7:0] other_rd;
        string      tag;
        tag      = $sformatf("v%0d", idx);
        other_rd = v.m ? m0_rdata : m1_rdata;
        @(negedge clk);
        set_req(v.m, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clk);
        nstb = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!s_stb) break;
            nstb++;
            if (c == 1) begin
                chk({tag, "_s_addr"}, 32'(s_addr), 32'(v.addr));
                chk({tag, "_s_we"}, 32'(s_we), 32'(v.we));
                chk({tag, "_s_wdata"}, 32'(s_wdata), 32'(v.wdata));
                chk({tag, "_grant"}, 32'(grant), v.m ? 32'h2 : 32'h1);
                chk({tag, "_busy"}, 32'(busy), 32'h1);
                if (v.drop) set_req(v.m, 1'b0, v.we, v.addr, v.wdata);
            end
            if (c == v.lat) begin
                s_ack = 1'b1;
                s_rdata = v.srd;
            end
            @(negedge clk);
            s_ack = 1'b0;
        end
        chk({tag, "_nstb"}, 32'(nstb), 32'(v.exp_nstb));
        chk({tag, "_ack"}, 32'(v.m ? m1_ack : m0_ack), 32'(v.exp_ack));
        chk({tag, "_err"}, 32'(v.m ? m1_err : m0_err), 32'(v.exp_err));
        chk({tag, "_rdata"}, 32'(v.m ? m1_rdata : m0_rdata), 32'(v.exp_rdata));
        chk({tag, "_other_ackerr"}, 32'(v.m ? {m0_ack, m0_err} : {m1_ack, m1_err}), 32'h0);
        chk({tag, "_other_rdata"}, 32'(v.m ? m0_rdata : m1_rdata), 32'(other_rd));
        set_req(v.m, 1'b0, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk({tag, "_idle"}, 32'({m0_ack, m0_err, m1_ack, m1_err, busy, grant, s_stb}), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          m  we addr wdata  lat srd    drop ack err rdata  nstb
        vecs[0] = '{1'b0, 1'b1, 2'd0, 8'h41, 1,  8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 8'h00, 3,  8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 3};
        vecs[2] = '{1'b0, 1'b0, 2'd3, 8'h00, 0,  8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 15};
        vecs[3] = '{1'b0, 1'b0, 2'd1, 8'h00, 1,  8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 8'h99, 15, 8'h77, 1'b0, 1'b1, 1'b0, 8'h77, 15};
        vecs[5] = '{1'b0, 1'b0, 2'd2, 8'h12, 4,  8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 4};
        vecs[6] = '{1'b1, 1'b0, 2'd3, 8'h00, 0,  8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 15};

        reset_n = 1'b0;
        m0_stb = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_stb = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        s_ack = 0; s_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({s_stb, s_we, s_addr, grant, busy, m0_ack, m0_err, m1_ack, m1_err}),
            32'h0);
        chk("reset_data", {8'h0, s_wdata, m0_rdata, m1_rdata}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Contention out of reset: grants must alternate m0, m1, m0, m1.
        m0_stb = 1; m0_we = 0; m0_addr = 2'd0;
        m1_stb = 1; m1_we = 0; m1_addr = 2'd1;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!s_stb && w < 5) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("cont%0d_grant", k), 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("cont%0d_addr", k), 32'(s_addr), (k % 2 == 0) ? 32'h0 : 32'h1);
            s_ack = 1'b1;
            s_rdata = 8'(8'h10 + k);
            @(negedge clk);
            s_ack = 1'b0;
            chk($sformatf("cont%0d_acks", k), 32'({m1_ack, m0_ack}),
                (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("cont%0d_rdata", k), 32'((k % 2 == 0) ? m0_rdata : m1_rdata),
                32'(8'h10 + k));
        end
        m0_stb = 0; m1_stb = 0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // s_ack outside BUS is ignored.
        s_ack = 1'b1;
        s_rdata = 8'hEE;
        repeat (2) @(negedge clk);
        s_ack = 1'b0;
        chk("stray_ack", 32'({m0_ack, m1_ack, busy, s_stb}), 32'h0);
        chk("stray_rdata", 32'({m0_rdata, m1_rdata}), 32'hA5FF);

        // Reset asserted mid-BUS: s_stb falls immediately, no ack follows.
        @(negedge clk);
        set_req(1'b1, 1'b1, 1'b0, 2'd2, 8'h00);
        @(negedge clk);
        chk("midrst_inbus", 32'(s_stb), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_async", 32'({s_stb, busy, grant}), 32'h0);
        chk("midrst_rdata", 32'({m0_rdata, m1_rdata}), 32'h0);
        @(negedge clk);
        set_req(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
        s_ack = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        s_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_noack", 32'({m0_ack, m0_err, m1_ack, m1_err, s_stb}), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
